// File: rtl/spike_pkg.sv
// rtl/spike_pkg.sv - shared types and helpers for the spike encoder
// Contents: encoder state enum, WIDTH-bit bit reversal, frame length helper.
package spike_pkg;

  // Widest step code bitrev can handle.
  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } enc_state_t;

  // Reverse the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bitrev(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    logic [4:0]       idx;
    r = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) begin
        idx    = 5'(w - 1 - b);
        r[idx] = v[b];
      end
    end
    return r;
  endfunction

  // Busy cycles of one frame, counted from the acceptance edge.
  function automatic int frame_cycles(input int warmup, input int width, input int hold);
    return warmup + ((1 << width) - 1) * hold;
  endfunction

endpackage

// File: rtl/spike_step_gen.sv
// rtl/spike_step_gen.sv - frame sequencer for the spike encoder
// Ports: clk, rst (sync, active high), load_valid, stop in; accept (handshake
// firing this edge), step_valid / step_code (RUN flag and bitrev(step) for the
// cycle after this edge), load_ready, busy, frame_done (registered) out.
module spike_step_gen
  import spike_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HOLD   = 7,
  parameter int WARMUP = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic             stop,
  output logic             accept,
  output logic             step_valid,
  output logic [WIDTH-1:0] step_code,
  output logic             load_ready,
  output logic             busy,
  output logic             frame_done
);

  // A zero-length warmup still needs a one-bit register to keep widths legal.
  localparam int WW   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int HC_W = $clog2(HOLD + 1);

  // The WARMUP parameter shadows the imported enum literal, so states are
  // always named through the package scope.
  enc_state_t      state, state_n;
  logic [WW-1:0]   warm_cnt, warm_n;
  logic [HC_W-1:0] hold_cnt, hold_n;
  logic [WIDTH-1:0] step, step_n;
  logic            done_n;

  // load_ready is high exactly when the registered state is IDLE.
  assign accept = (state == spike_pkg::IDLE) && load_valid && !stop;

  always_comb begin
    state_n = state;
    warm_n  = warm_cnt;
    hold_n  = hold_cnt;
    step_n  = step;
    done_n  = 1'b0;
    case (state)
      spike_pkg::IDLE: begin
        if (accept) begin
          step_n = WIDTH'(1);
          hold_n = '0;
          if (WARMUP == 0) begin
            state_n = spike_pkg::RUN;
          end else begin
            state_n = spike_pkg::WARMUP;
            warm_n  = WW'(WARMUP);
          end
        end
      end
      spike_pkg::WARMUP: begin
        if (stop) begin
          state_n = spike_pkg::IDLE;
        end else begin
          warm_n = warm_cnt - WW'(1);
          if (warm_cnt == WW'(1)) state_n = spike_pkg::RUN;
        end
      end
      spike_pkg::RUN: begin
        if (stop) begin
          state_n = spike_pkg::IDLE;
        end else if (hold_cnt == HC_W'(HOLD - 1)) begin
          hold_n = '0;
          // Last step ends the frame instead of letting step wrap to 0.
          if (step == '1) begin
            state_n = spike_pkg::IDLE;
            done_n  = 1'b1;
          end else begin
            step_n = step + WIDTH'(1);
          end
        end else begin
          hold_n = hold_cnt + HC_W'(1);
        end
      end
      default: state_n = spike_pkg::IDLE;
    endcase
  end

  // Look-ahead outputs so the top can register spikes in step with the state.
  always_comb begin
    step_valid = (state_n == spike_pkg::RUN);
    step_code  = WIDTH'(bitrev(MAX_W'(step_n), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= spike_pkg::IDLE;
      warm_cnt   <= '0;
      hold_cnt   <= '0;
      step       <= '0;
      busy       <= 1'b0;
      load_ready <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      warm_cnt   <= warm_n;
      hold_cnt   <= hold_n;
      step       <= step_n;
      busy       <= (state_n != spike_pkg::IDLE);
      load_ready <= (state_n == spike_pkg::IDLE);
      frame_done <= done_n;
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - rate-coding spike encoder top level
// Ports: clk, rst (sync, active high), load_valid, load_data (HEIGHT values of
// WIDTH bits), stop in; load_ready, spikes[HEIGHT], busy, frame_done out.
// HOLD must be at least 1.
module spike_encoder
  import spike_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 7,
  parameter int HOLD   = HEIGHT,
  parameter int WARMUP = HEIGHT * 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [HEIGHT*WIDTH-1:0] load_data,
  input  logic                    stop,
  output logic [HEIGHT-1:0]       spikes,
  output logic                    busy,
  output logic                    frame_done
);

  logic                    accept;
  logic                    step_valid;
  logic [WIDTH-1:0]        step_code;
  logic [HEIGHT*WIDTH-1:0] values, values_n;
  logic [HEIGHT-1:0]       spikes_n;

  spike_step_gen #(
    .WIDTH (WIDTH),
    .HOLD  (HOLD),
    .WARMUP(WARMUP)
  ) u_step_gen (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .stop      (stop),
    .accept    (accept),
    .step_valid(step_valid),
    .step_code (step_code),
    .load_ready(load_ready),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // Compare against the values that will be held after this edge, so a load
  // straight into RUN (no warmup) spikes from its first step.
  always_comb begin
    values_n = accept ? load_data : values;
    spikes_n = '0;
    for (int i = 0; i < HEIGHT; i++) begin
      spikes_n[i] = step_valid && (values_n[i*WIDTH +: WIDTH] >= step_code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      values <= '0;
      spikes <= '0;
    end else begin
      values <= values_n;
      spikes <= spikes_n;
    end
  end

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - self-checking bench for spike_encoder
module tb_spike_encoder;
  import spike_pkg::*;

  localparam int W  = 8;
  localparam int H  = 7;
  localparam int HD = 7;
  localparam int WU = 28;
  localparam int FC = 1813;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, load_valid, stop;
  logic [H*W-1:0] load_data;
  logic           load_ready, busy, frame_done;
  logic [H-1:0]   spikes;

  logic       s_rst, s_load_valid, s_stop;
  logic [5:0] s_load_data;
  logic       s_load_ready, s_busy, s_frame_done;
  logic [1:0] s_spikes;

  int n_checks = 0;
  int n_errors = 0;
  int line_cnt [H];

  spike_encoder dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .stop(stop), .spikes(spikes), .busy(busy),
    .frame_done(frame_done)
  );

  spike_encoder #(.WIDTH(3), .HEIGHT(2), .HOLD(1), .WARMUP(0)) dut_small (
    .clk(clk), .rst(s_rst), .load_valid(s_load_valid), .load_ready(s_load_ready),
    .load_data(s_load_data), .stop(s_stop), .spikes(s_spikes), .busy(s_busy),
    .frame_done(s_frame_done)
  );

  function automatic int rev(input int v, input int w);
    int r;
    int x;
    r = 0;
    x = v;
    for (int b = 0; b < w; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  // Sample j counts cycles after the acceptance edge (j = 0 is the first).
  function automatic logic exp_spike(input int value, input int j, input int wu,
                                     input int hd, input int w);
    int s;
    if (j < wu) return 1'b0;
    s = (j - wu) / hd + 1;
    return value >= rev(s, w);
  endfunction

  function automatic logic [H*W-1:0] rand_data();
    return (H*W)'({$urandom(), $urandom()});
  endfunction

  task automatic run_frame(input logic [H*W-1:0] data, input bit keep_valid,
                           input string tag, output logic [H*W-1:0] next_data);
    int bad_spk;
    int bad_ctl;
    logic [H-1:0] exp_v;
    bad_spk = 0;
    bad_ctl = 0;
    next_data = data;
    load_data = data;
    load_valid = 1'b1;
    n_checks++;
    if (load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept_ready: load_ready=%b required 1", tag, load_ready);
    end
    @(posedge clk); #1;
    if (!keep_valid) load_valid = 1'b0;
    for (int i = 0; i < H; i++) line_cnt[i] = 0;
    for (int j = 0; j <= FC; j++) begin
      if (j < FC) begin
        for (int i = 0; i < H; i++) begin
          exp_v[i] = exp_spike(int'(data[i*W +: W]), j, WU, HD, W);
          if (spikes[i] === 1'b1) line_cnt[i]++;
        end
        if (spikes !== exp_v) bad_spk++;
        if (busy !== 1'b1 || load_ready !== 1'b0 || frame_done !== 1'b0) bad_ctl++;
        if (keep_valid) load_data = rand_data();
        @(posedge clk); #1;
      end else begin
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || load_ready !== 1'b1 || spikes !== '0) begin
          n_errors++;
          $display("FAIL %s frame_end: done=%b busy=%b ready=%b spikes=%h required 1 0 1 00",
                   tag, frame_done, busy, load_ready, spikes);
        end
        if (keep_valid) begin
          next_data = rand_data();
          load_data = next_data;
        end
      end
    end
    n_checks++;
    if (bad_spk != 0) begin
      n_errors++;
      $display("FAIL %s spike_trace: %0d bad cycles required 0", tag, bad_spk);
    end
    n_checks++;
    if (bad_ctl != 0) begin
      n_errors++;
      $display("FAIL %s busy_ctl: %0d bad cycles required 0", tag, bad_ctl);
    end
    for (int i = 0; i < H; i++) begin
      n_checks++;
      if (line_cnt[i] != int'(data[i*W +: W]) * HD) begin
        n_errors++;
        $display("FAIL %s line%0d_count: got %0d required %0d", tag, i, line_cnt[i],
                 int'(data[i*W +: W]) * HD);
      end
    end
  endtask

  task automatic accept_and_advance(input logic [H*W-1:0] data, input int n);
    load_data = data;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle_reset(input string tag);
    n_checks++;
    if (spikes !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: spikes=%h busy=%b done=%b ready=%b required 00 0 0 1",
               tag, spikes, busy, frame_done, load_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; stop = 1'b0; load_data = '0;
    s_rst = 1'b1; s_load_valid = 1'b0; s_stop = 1'b0; s_load_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_reset("reset_state");
    n_checks++;
    if (s_spikes !== 2'b00 || s_busy !== 1'b0 || s_frame_done !== 1'b0 || s_load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state_small: spikes=%b busy=%b done=%b ready=%b required 00 0 0 1",
               s_spikes, s_busy, s_frame_done, s_load_ready);
    end
    rst = 1'b0;
    s_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_frame();
    logic [H*W-1:0] nd;
    run_frame('0, 1'b0, "zero", nd);
  endtask

  task automatic test_pattern();
    logic [H*W-1:0] d;
    logic [H*W-1:0] nd;
    d = '0;
    d[0 +: W] = 8'd255;
    d[W +: W] = 8'd128;
    d[2*W +: W] = 8'd1;
    run_frame(d, 1'b0, "pattern", nd);
    n_checks++;
    if (line_cnt[0] != 1785 || line_cnt[1] != 896 || line_cnt[2] != 7) begin
      n_errors++;
      $display("FAIL pattern_counts: got %0d %0d %0d required 1785 896 7",
               line_cnt[0], line_cnt[1], line_cnt[2]);
    end
  endtask

  task automatic test_random();
    logic [H*W-1:0] nd;
    for (int k = 0; k < 2; k++) run_frame(rand_data(), 1'b0, "random", nd);
  endtask

  task automatic test_back_to_back();
    logic [H*W-1:0] nd;
    logic [H*W-1:0] nd2;
    run_frame(rand_data(), 1'b1, "b2b_first", nd);
    run_frame(nd, 1'b0, "b2b_second", nd2);
  endtask

  task automatic test_stop();
    logic [H*W-1:0] nd;
    int bad;
    accept_and_advance(rand_data(), WU + 9 * HD);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check_idle_reset("stop_run");
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL stop_quiet: %0d bad cycles required 0", bad);
    end
    stop = 1'b1;
    load_valid = 1'b1;
    load_data = rand_data();
    @(posedge clk); #1;
    stop = 1'b0;
    load_valid = 1'b0;
    check_idle_reset("stop_idle_drop");
    run_frame(rand_data(), 1'b0, "after_stop", nd);
    @(posedge clk); #1;
    accept_and_advance(rand_data(), FC - 1);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check_idle_reset("stop_last_cycle");
  endtask

  task automatic test_midframe_reset();
    logic [H*W-1:0] nd;
    accept_and_advance(rand_data(), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("reset_warmup");
    accept_and_advance(rand_data(), WU + 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle_reset("reset_run");
    run_frame(rand_data(), 1'b0, "after_reset", nd);
  endtask

  task automatic test_small_sweep();
    int pat [7] = '{1, 1, 0, 1, 1, 1, 0};
    int fc;
    int bad;
    int cnt0;
    fc = frame_cycles(0, 3, 1);
    bad = 0;
    cnt0 = 0;
    s_load_data = {3'd2, 3'd5};
    s_load_valid = 1'b1;
    @(posedge clk); #1;
    s_load_valid = 1'b0;
    for (int j = 0; j < fc; j++) begin
      if (s_spikes[0] !== pat[j][0]) bad++;
      if (s_spikes[1] !== exp_spike(2, j, 0, 1, 3)) bad++;
      if (s_busy !== 1'b1) bad++;
      if (s_spikes[0] === 1'b1) cnt0++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL small_trace: %0d bad samples required 0", bad);
    end
    n_checks++;
    if (cnt0 != 5) begin
      n_errors++;
      $display("FAIL small_count: got %0d required 5", cnt0);
    end
    n_checks++;
    if (s_frame_done !== 1'b1 || s_spikes !== 2'b00 || s_load_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL small_end: done=%b spikes=%b ready=%b required 1 00 1",
               s_frame_done, s_spikes, s_load_ready);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_frame();
    test_pattern();
    test_random();
    test_back_to_back();
    test_stop();
    test_midframe_reset();
    test_small_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
